// File: rtl/ts_ep_in_arbiter.sv
// Round-robin arbiter that streams one of two byte requesters into the shared
// USB EP3 IN buffer, commits the transfer and waits for an acknowledge.
module ts_ep_in_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] max_len,
  input  logic              req0_valid,
  input  logic [7:0]        req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [7:0]        req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] usb_in_addr,
  output logic [7:0]        usb_in_data,
  output logic              usb_in_wren,
  input  logic              usb_in_ready,
  output logic              usb_in_commit,
  output logic [ADDR_W-1:0] usb_in_commit_len,
  input  logic              usb_in_commit_ack,
  output logic              grant,
  output logic              busy,
  output logic [CNT_W-1:0]  commits0,
  output logic [CNT_W-1:0]  commits1,
  output logic [CNT_W-1:0]  ack_timeouts
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, COMMIT, WAIT_ACK} state_t;

  state_t            state_reg, state_next;
  logic              grant_reg, grant_next;
  logic              ptr_reg, ptr_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        data_reg, data_next;
  logic              wren_reg, wren_next;
  logic              commit_reg, commit_next;
  logic [ADDR_W-1:0] len_reg, len_next;
  logic [CNT_W-1:0]  c0_reg, c0_next;
  logic [CNT_W-1:0]  c1_reg, c1_next;
  logic [CNT_W-1:0]  to_reg, to_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic              busy_reg;
  logic              ack_s1_reg, ack_s2_reg, ack_s3_reg;

  logic              ack_rise;
  logic              ptr_valid, oth_valid;
  logic              sel_valid, sel_last;
  logic [7:0]        sel_data;
  logic [ADDR_W:0]   cnt_inc;

  assign ack_rise  = ack_s2_reg & ~ack_s3_reg;
  assign ptr_valid = ptr_reg ? req1_valid : req0_valid;
  assign oth_valid = ptr_reg ? req0_valid : req1_valid;
  assign sel_valid = grant_reg ? req1_valid : req0_valid;
  assign sel_data  = grant_reg ? req1_data  : req0_data;
  assign sel_last  = grant_reg ? req1_last  : req0_last;
  assign cnt_inc   = {1'b0, cnt_reg} + {{ADDR_W{1'b0}}, 1'b1};

  assign req0_ready = (state_reg == STREAM) && !grant_reg && usb_in_ready;
  assign req1_ready = (state_reg == STREAM) &&  grant_reg && usb_in_ready;

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    ptr_next    = ptr_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    wren_next   = 1'b0;
    commit_next = 1'b0;
    len_next    = len_reg;
    c0_next     = c0_reg;
    c1_next     = c1_reg;
    to_next     = to_reg;
    to_cnt_next = to_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (usb_in_ready && (max_len != '0) && (ptr_valid || oth_valid)) begin
          grant_next = ptr_valid ? ptr_reg : ~ptr_reg;
          cnt_next   = '0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (usb_in_ready && sel_valid) begin
          wren_next = 1'b1;
          addr_next = cnt_reg;
          data_next = sel_data;
          cnt_next  = cnt_inc[ADDR_W-1:0];
          // >= rather than == so a max_len lowered mid-transfer still ends it
          if (sel_last || (cnt_inc >= {1'b0, max_len})) begin
            len_next   = cnt_inc[ADDR_W-1:0];
            state_next = COMMIT;
          end
        end
      end
      COMMIT: begin
        commit_next = 1'b1;
        if (grant_reg) c1_next = c1_reg + CNT_W'(1);
        else           c0_next = c0_reg + CNT_W'(1);
        ptr_next    = ~grant_reg;
        to_cnt_next = '0;
        state_next  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_rise) begin
          state_next = IDLE;
        end else if (to_cnt_reg == TO_W'(ACK_TIMEOUT - 1)) begin
          to_next    = to_reg + CNT_W'(1);
          state_next = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      grant_reg  <= 1'b0;
      ptr_reg    <= 1'b0;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      wren_reg   <= 1'b0;
      commit_reg <= 1'b0;
      len_reg    <= '0;
      c0_reg     <= '0;
      c1_reg     <= '0;
      to_reg     <= '0;
      to_cnt_reg <= '0;
      busy_reg   <= 1'b0;
      ack_s1_reg <= 1'b0;
      ack_s2_reg <= 1'b0;
      ack_s3_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      ptr_reg    <= ptr_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      wren_reg   <= wren_next;
      commit_reg <= commit_next;
      len_reg    <= len_next;
      c0_reg     <= c0_next;
      c1_reg     <= c1_next;
      to_reg     <= to_next;
      to_cnt_reg <= to_cnt_next;
      busy_reg   <= (state_next != IDLE);
      ack_s1_reg <= usb_in_commit_ack;
      ack_s2_reg <= ack_s1_reg;
      ack_s3_reg <= ack_s2_reg;
    end
  end

  assign usb_in_addr       = addr_reg;
  assign usb_in_data       = data_reg;
  assign usb_in_wren       = wren_reg;
  assign usb_in_commit     = commit_reg;
  assign usb_in_commit_len = len_reg;
  assign grant             = grant_reg;
  assign busy              = busy_reg;
  assign commits0          = c0_reg;
  assign commits1          = c1_reg;
  assign ack_timeouts      = to_reg;

endmodule

// File: tb/tb_ts_ep_in_arbiter.sv
// Randomized bench for ts_ep_in_arbiter: byte queues per requester feed the DUT
// and a transfer-level model predicts every committed transfer.
module tb_ts_ep_in_arbiter;

  localparam int ADDR_W = 11;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] max_len;
  logic              req0_valid, req0_last, req0_ready;
  logic [7:0]        req0_data;
  logic              req1_valid, req1_last, req1_ready;
  logic [7:0]        req1_data;
  logic [ADDR_W-1:0] usb_in_addr;
  logic [7:0]        usb_in_data;
  logic              usb_in_wren, usb_in_ready, usb_in_commit, usb_in_commit_ack;
  logic [ADDR_W-1:0] usb_in_commit_len;
  logic              grant, busy;
  logic [CNT_W-1:0]  commits0, commits1, ack_timeouts;

  ts_ep_in_arbiter #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .max_len(max_len),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .usb_in_addr(usb_in_addr), .usb_in_data(usb_in_data), .usb_in_wren(usb_in_wren),
    .usb_in_ready(usb_in_ready), .usb_in_commit(usb_in_commit),
    .usb_in_commit_len(usb_in_commit_len), .usb_in_commit_ack(usb_in_commit_ack),
    .grant(grant), .busy(busy), .commits0(commits0), .commits1(commits1),
    .ack_timeouts(ack_timeouts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } item_t;

  item_t      dq0[$], dq1[$];   // bytes still to be offered to the DUT
  item_t      mq0[$], mq1[$];   // bytes the model has not yet seen committed
  logic [7:0] cap[$];           // buffer writes since the last commit

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, last_wren_cyc = -10, wa_start = 0, wa_len = -1;
  int ack_cd = -1, ack_hold = 0, acc_total = 0;
  int exp_c0 = 0, exp_c1 = 0;
  bit ack_en = 1'b1, rand_ready = 1'b0, ready_level = 1'b1;
  bit stall_prev = 1'b0, busy_prev = 1'b0, mptr = 1'b0;

  task automatic push_bytes(input int n, input int len, input bit seq, input logic [7:0] base,
                            input bit end_last, input bit rand_last);
    item_t it;
    for (int i = 0; i < len; i++) begin
      it.d = seq ? base + 8'(i) : 8'($urandom_range(0, 255));
      it.l = (end_last && (i == len - 1)) || (rand_last && ($urandom_range(0, 5) == 0));
      if (n == 0) begin dq0.push_back(it); mq0.push_back(it); end
      else        begin dq1.push_back(it); mq1.push_back(it); end
    end
  endtask

  // Model: round-robin pick among requesters with pending bytes, transfer
  // ends on a last flag or after max_len bytes.
  task automatic model_commit();
    logic [7:0] exp_b[$];
    item_t      it;
    bit         who;
    bit         ok;
    who = mptr;
    if ((who ? mq1.size() : mq0.size()) == 0) who = ~mptr;
    n_checks++;
    if (mq0.size() == 0 && mq1.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_commit: got commit len %0d, required no commit", usb_in_commit_len);
      return;
    end
    forever begin
      if ((who ? mq1.size() : mq0.size()) == 0) break;
      it = who ? mq1.pop_front() : mq0.pop_front();
      exp_b.push_back(it.d);
      if (it.l || exp_b.size() >= int'(max_len)) break;
    end
    if (who) exp_c1++; else exp_c0++;
    $display("[%0t] commit req%0d len=%0d exp_len=%0d commits0=%0d commits1=%0d", $time, grant,
             usb_in_commit_len, exp_b.size(), commits0, commits1);
    n_checks++;
    if (grant !== who) begin
      n_fail++; $display("FAIL grant: got %0d, required %0d", grant, who);
    end
    n_checks++;
    if (usb_in_commit_len !== ADDR_W'(exp_b.size())) begin
      n_fail++; $display("FAIL commit_len: got %0d, required %0d", usb_in_commit_len, exp_b.size());
    end
    ok = (cap.size() == exp_b.size());
    for (int i = 0; ok && i < exp_b.size(); i++) if (cap[i] !== exp_b[i]) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL payload: got %0d bytes (first %h), required %0d bytes (first %h)",
                         cap.size(), (cap.size() > 0) ? cap[0] : 8'h00, exp_b.size(), exp_b[0]);
    end
    n_checks++;
    if (cyc - last_wren_cyc != 1) begin
      n_fail++; $display("FAIL commit_timing: got %0d cycles after last wren, required 1", cyc - last_wren_cyc);
    end
    n_checks++;
    if (commits0 !== CNT_W'(exp_c0) || commits1 !== CNT_W'(exp_c1)) begin
      n_fail++; $display("FAIL commit_counters: got %0d/%0d, required %0d/%0d", commits0, commits1, exp_c0, exp_c1);
    end
    mptr = ~who;
    cap.delete();
    if (ack_en) ack_cd = $urandom_range(1, 6);
  endtask

  task automatic drive_heads();
    req0_valid = (dq0.size() != 0);
    req0_data  = req0_valid ? dq0[0].d : 8'h00;
    req0_last  = req0_valid ? dq0[0].l : 1'b0;
    req1_valid = (dq1.size() != 0);
    req1_data  = req1_valid ? dq1[0].d : 8'h00;
    req1_last  = req1_valid ? dq1[0].l : 1'b0;
  endtask

  // One clock: monitor at negedge, then update stimulus just after posedge.
  task automatic step();
    bit acc0, acc1;
    @(negedge clk);
    cyc++;
    n_checks++;
    if (!usb_in_ready && (req0_ready || req1_ready)) begin
      n_fail++; $display("FAIL ready_gap: got req_ready %0d%0d, required 00", req1_ready, req0_ready);
    end
    if (stall_prev) begin
      n_checks++;
      if (usb_in_wren) begin
        n_fail++; $display("FAIL stall_wren: got wren 1, required 0");
      end
    end
    stall_prev = !usb_in_ready;
    if (usb_in_wren) begin
      n_checks++;
      if (usb_in_addr !== ADDR_W'(cap.size())) begin
        n_fail++; $display("FAIL addr: got %0d, required %0d", usb_in_addr, cap.size());
      end
      cap.push_back(usb_in_data);
      last_wren_cyc = cyc;
    end
    if (usb_in_commit) begin
      wa_start = cyc;
      model_commit();
    end
    if (busy_prev && !busy) wa_len = cyc - wa_start;
    busy_prev = busy;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (acc0) begin void'(dq0.pop_front()); acc_total++; end
    if (acc1) begin void'(dq1.pop_front()); acc_total++; end
    if (ack_hold > 0) begin
      ack_hold--;
      if (ack_hold == 0) usb_in_commit_ack = 1'b0;
    end
    if (ack_cd > 0) begin
      ack_cd--;
      if (ack_cd == 0) begin
        usb_in_commit_ack = 1'b1; ack_hold = 2; ack_cd = -1;
      end
    end
    usb_in_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_level;
    drive_heads();
  endtask

  task automatic run_until_done(input int budget);
    int k = 0;
    while (!(dq0.size() == 0 && dq1.size() == 0 && mq0.size() == 0 && mq1.size() == 0 &&
             !busy && ack_cd < 0 && ack_hold == 0) && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++; $display("FAIL drain_timeout: got %0d queued bytes left, required 0", mq0.size() + mq1.size());
    end
    repeat (4) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dq0.delete(); dq1.delete(); mq0.delete(); mq1.delete(); cap.delete();
    usb_in_commit_ack = 1'b0; ack_cd = -1; ack_hold = 0;
    rand_ready = 1'b0; ready_level = 1'b1; usb_in_ready = 1'b1; ack_en = 1'b1;
    drive_heads();
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    mptr = 1'b0; exp_c0 = 0; exp_c1 = 0;
    stall_prev = 1'b0; busy_prev = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    req0_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if ({usb_in_wren, usb_in_commit, usb_in_addr, usb_in_data, usb_in_commit_len, commits0, commits1,
         ack_timeouts, busy, grant, req0_ready, req1_ready} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got wren=%0d commit=%0d addr=%0d busy=%0d c0=%0d, required all 0",
                         usb_in_wren, usb_in_commit, usb_in_addr, busy, commits0);
    end
    do_reset();
  endtask

  task automatic test_max_len4();
    do_reset();
    max_len = 4;
    push_bytes(0, 8, 1'b1, 8'hA0, 1'b0, 1'b0);
    drive_heads();
    run_until_done(200);
    n_checks++;
    if (commits0 !== 2 || commits1 !== 0 || usb_in_commit_len !== 4) begin
      n_fail++; $display("FAIL max_len4: got commits0=%0d commits1=%0d len=%0d, required 2/0/4",
                         commits0, commits1, usb_in_commit_len);
    end
  endtask

  task automatic test_last();
    do_reset();
    max_len = 188;
    push_bytes(1, 10, 1'b0, 8'h00, 1'b1, 1'b0);
    drive_heads();
    run_until_done(200);
    n_checks++;
    if (commits1 !== 1 || commits0 !== 0 || usb_in_commit_len !== 10) begin
      n_fail++; $display("FAIL early_last: got commits1=%0d len=%0d, required 1/10", commits1, usb_in_commit_len);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    max_len = 2;
    push_bytes(0, 4, 1'b1, 8'h10, 1'b0, 1'b0);
    push_bytes(1, 4, 1'b1, 8'h80, 1'b0, 1'b0);
    drive_heads();
    run_until_done(300);
    n_checks++;
    if (commits0 !== 2 || commits1 !== 2) begin
      n_fail++; $display("FAIL alternate: got commits0=%0d commits1=%0d, required 2/2", commits0, commits1);
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    do_reset();
    max_len = 16;
    ack_en = 1'b0;
    wa_len = -1;
    push_bytes(0, 2, 1'b1, 8'h30, 1'b1, 1'b0);
    push_bytes(1, 3, 1'b1, 8'h50, 1'b1, 1'b0);
    drive_heads();
    while (wa_len < 0 && k < 300) begin step(); k++; end
    n_checks++;
    if (wa_len != 64) begin
      n_fail++; $display("FAIL wait_ack_len: got %0d, required 64", wa_len);
    end
    n_checks++;
    if (ack_timeouts !== 1) begin
      n_fail++; $display("FAIL ack_timeouts: got %0d, required 1", ack_timeouts);
    end
    ack_en = 1'b1;
    run_until_done(300);
    n_checks++;
    if (commits0 !== 1 || commits1 !== 1 || ack_timeouts !== 1) begin
      n_fail++; $display("FAIL after_timeout: got %0d/%0d/%0d, required 1/1/1", commits0, commits1, ack_timeouts);
    end
  endtask

  task automatic test_stall();
    int start, k = 0;
    do_reset();
    max_len = 16;
    push_bytes(1, 8, 1'b1, 8'hC0, 1'b1, 1'b0);
    drive_heads();
    start = acc_total;
    while (acc_total < start + 3 && k < 50) begin step(); k++; end
    ready_level = 1'b0;
    usb_in_ready = 1'b0;
    repeat (5) step();
    ready_level = 1'b1;
    run_until_done(200);
    n_checks++;
    if (commits1 !== 1 || usb_in_commit_len !== 8) begin
      n_fail++; $display("FAIL stall_resume: got commits1=%0d len=%0d, required 1/8", commits1, usb_in_commit_len);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      max_len = ADDR_W'($urandom_range(1, 8));
      rand_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
        push_bytes(0, $urandom_range(1, 12), 1'b0, 8'h00, 1'b1, 1'b1);
        push_bytes(1, $urandom_range(1, 12), 1'b0, 8'h00, 1'b1, 1'b1);
      end
      drive_heads();
      run_until_done(3000);
      n_checks++;
      if (commits0 !== CNT_W'(exp_c0) || commits1 !== CNT_W'(exp_c1) || ack_timeouts !== 0) begin
        n_fail++; $display("FAIL random_counts: got %0d/%0d/%0d, required %0d/%0d/0",
                           commits0, commits1, ack_timeouts, exp_c0, exp_c1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int start, k = 0;
    do_reset();
    max_len = 4;
    push_bytes(0, 4, 1'b1, 8'h60, 1'b0, 1'b0);
    drive_heads();
    run_until_done(200);
    max_len = 8;
    push_bytes(0, 8, 1'b1, 8'h70, 1'b0, 1'b0);
    drive_heads();
    start = acc_total;
    while (acc_total < start + 2 && k < 50) begin step(); k++; end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (usb_in_wren || usb_in_commit || busy || commits0 !== 0 || commits1 !== 0 || ack_timeouts !== 0) begin
      n_fail++; $display("FAIL reset_mid: got wren=%0d commit=%0d busy=%0d c0=%0d, required all 0",
                         usb_in_wren, usb_in_commit, busy, commits0);
    end
    do_reset();
    max_len = 0;
    push_bytes(0, 1, 1'b1, 8'hEE, 1'b1, 1'b0);
    drive_heads();
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL max_len_zero: got busy %0d, required 0", busy);
      end
    end
    max_len = 4;
    run_until_done(200);
    n_checks++;
    if (commits0 !== 1) begin
      n_fail++; $display("FAIL max_len_restore: got commits0=%0d, required 1", commits0);
    end
  endtask

  initial begin
    reset = 1'b1; max_len = 0; usb_in_ready = 1'b1; usb_in_commit_ack = 1'b0;
    drive_heads();
    test_reset();
    test_max_len4();
    test_last();
    test_alternate();
    test_timeout();
    test_stall();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_ep_in_arbiter.md
Name: ts_ep_in_arbiter

Overview:
- Shares the single USB Endpoint 3 IN buffer between two byte-stream requesters, e.g. the TS FIFO path and a status/diagnostic message source.
- Grants one requester per USB transfer using round-robin priority.
- Writes the granted requester's bytes into the endpoint buffer, issues the commit, then waits for the commit acknowledge with a timeout.
- Sits between the TS/status producers and the USB endpoint buffer interface.

Parameters:
ADDR_W, 11, width of the endpoint buffer address and of the length fields
ACK_TIMEOUT, 64, number of cycles in WAIT_ACK before the transfer is abandoned
CNT_W, 16, width of the status counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
max_len  input  ADDR_W  maximum bytes per commit; 0 disables all grants
req0_valid  input  1  requester 0 byte valid
req0_data  input  8  requester 0 byte
req0_last  input  1  requester 0 final byte; forces an early commit
req0_ready  output  1  requester 0 byte accepted when valid&ready
req1_valid  input  1  requester 1 byte valid
req1_data  input  8  requester 1 byte
req1_last  input  1  requester 1 final byte
req1_ready  output  1  requester 1 byte accepted when valid&ready
usb_in_addr  output  ADDR_W  endpoint buffer write address
usb_in_data  output  8  endpoint buffer write data
usb_in_wren  output  1  endpoint buffer write strobe
usb_in_ready  input  1  endpoint buffer available
usb_in_commit  output  1  one-cycle commit pulse
usb_in_commit_len  output  ADDR_W  number of bytes in the committed transfer
usb_in_commit_ack  input  1  commit acknowledge, asynchronous to clk
grant  output  1  current or last granted requester
busy  output  1  high when not in IDLE
commits0  output  CNT_W  transfers committed for requester 0
commits1  output  CNT_W  transfers committed for requester 1
ack_timeouts  output  CNT_W  transfers abandoned on timeout

Behaviour:
- Reset (synchronous): state=IDLE, byte counter=0, priority pointer=0, grant=0.
  - All outputs are 0: wren, commit, addr, data, commit_len, counters, busy.
  - Reset asserted in any state aborts immediately. No commit and no wren are issued in the cycle after reset.
- Ack synchronizer: 2-flop synchronizer on usb_in_commit_ack, plus a third flop for edge detection. ack_rise = sync2 & ~sync3.
- States: IDLE, STREAM, COMMIT, WAIT_ACK.
- IDLE:
  - Grant decision requires usb_in_ready=1 and max_len!=0.
  - The pointer requester wins if its valid is high; otherwise the other requester wins if its valid is high. If both are high, the pointer requester wins.
  - On a grant: latch grant, clear the counter, go to STREAM. No byte is accepted in the IDLE cycle.
- STREAM:
  - reqN_ready = (grant==N) & usb_in_ready. It is combinational and is 0 in all other states.
  - On accept: usb_in_addr<=counter, usb_in_data<=byte, and usb_in_wren=1 in the next cycle (1-cycle latency). Counter increments.
  - If the accepted byte has last=1, or counter==max_len-1: go to COMMIT and set usb_in_commit_len<=counter+1.
  - usb_in_ready low stalls the transfer: no accept, state holds.
- COMMIT:
  - usb_in_commit=1 for exactly this one cycle, which is the cycle after the final wren.
  - Increment commits[grant]. Toggle the pointer to ~grant. Clear the timeout counter. Go to WAIT_ACK.
- WAIT_ACK:
  - ack_rise: go to IDLE.
  - Timeout counter reaches ACK_TIMEOUT-1 without ack_rise: increment ack_timeouts and go to IDLE.
  - If ack_rise and the timeout coincide in the same cycle, the ack wins and ack_timeouts is not incremented.
- Ack edges outside WAIT_ACK are ignored.
- max_len changes are sampled only at the comparison. Lowering max_len below the current counter mid-STREAM commits on the next accepted byte.
- Counters wrap modulo 2^CNT_W. usb_in_commit_len holds its value until the next COMMIT.
- busy = (state!=IDLE), registered.

Test Plan:
1. max_len=4; req0 streams 0xA0..0xA7 with last=0 and ack returned 3 cycles after each commit -> two commits, each of len 4. Addr sequence is 0,1,2,3 with data A0..A3, then A4..A7. commit pulses 1 cycle after the 4th wren. commits0=2.
2. max_len=188; req1 sends 10 bytes with last on byte 10 -> commit_len=10, one commit pulse, commits1=1.
3. Both valid continuously, max_len=2 -> grants alternate 0,1,0,1. After 4 acks, commits0=2 and commits1=2.
4. Ack never returned, ACK_TIMEOUT=64 -> WAIT_ACK lasts 64 cycles, then ack_timeouts=1 and the state returns to IDLE. A new grant follows if valid is high.
5. usb_in_ready dropped for 5 cycles mid-STREAM -> reqN_ready=0 and no wren during the gap. Addresses resume contiguously with no lost or duplicated byte.
6. Reset asserted the cycle after the 2nd accepted byte -> next cycle has wren=0, commit=0, busy=0 and all counters 0. max_len=0 with valid high -> busy stays 0.
